// File: rtl/midi_pkg.sv
// Shared MIDI definitions: message types, parser states, real-time codes.
package midi_pkg;

   typedef enum logic [2:0] {
      MSG_OFF     = 3'b000,
      MSG_ON      = 3'b001,
      MSG_POLY_AT = 3'b010,
      MSG_CC      = 3'b011,
      MSG_PROG    = 3'b100,
      MSG_CHAN_AT = 3'b101,
      MSG_BEND    = 3'b110
   } msg_type_e;

   typedef enum logic [1:0] {
      ST_IDLE    = 2'd0,
      ST_WAIT_D1 = 2'd1,
      ST_WAIT_D2 = 2'd2,
      ST_SYSEX   = 2'd3
   } state_e;

   localparam logic [7:0] RT_CLOCK    = 8'hF8;
   localparam logic [7:0] RT_START    = 8'hFA;
   localparam logic [7:0] RT_STOP     = 8'hFC;
   localparam logic [7:0] RT_RESET    = 8'hFF;
   localparam logic [7:0] SYSEX_START = 8'hF0;
   localparam logic [7:0] SYSEX_END   = 8'hF7;

   function automatic logic [1:0] msg_len(input logic [2:0] t);
      if (t == MSG_PROG || t == MSG_CHAN_AT)
         return 2'd1;
      return 2'd2;
   endfunction

endpackage

// File: rtl/midi_byte_class.sv
// Combinational MIDI byte classifier.
module midi_byte_class
   import midi_pkg::*;
(
   input  logic [7:0] data,
   output logic       is_data,
   output logic       is_chan_status,
   output logic       is_common,
   output logic       is_rt,
   output logic [1:0] data_len
);

   always_comb begin
      is_data        = ~data[7];
      is_chan_status = data[7] & (data[6:4] != 3'b111);
      is_common      = (data[7:3] == 5'b11110);
      is_rt          = (data[7:3] == 5'b11111);
      data_len       = is_chan_status ? msg_len(data[6:4]) : 2'd0;
   end

endmodule

// File: rtl/midi_msg_parser.sv
// MIDI channel-message parser with running status, channel mask,
// real-time pass-through and SysEx skipping.
module midi_msg_parser
   import midi_pkg::*;
#(
   parameter logic [15:0] CHAN_MASK      = 16'hFFFF,
   parameter bit          RUNNING_STATUS = 1'b1,
   parameter bit          VEL0_OFF       = 1'b1,
   parameter int          CNT_W          = 8
)(
   input  logic             clk,
   input  logic             rst,
   input  logic             valid_byte,
   input  logic [7:0]       data,
   output logic             ev_valid,
   output logic [2:0]       ev_type,
   output logic [3:0]       ev_channel,
   output logic [6:0]       ev_data1,
   output logic [6:0]       ev_data2,
   output logic [13:0]      ev_bend,
   output logic             rt_valid,
   output logic [2:0]       rt_code,
   output logic             rst_cmd,
   output logic [CNT_W-1:0] drop_cnt
);

   logic       is_data;
   logic       is_chan_status;
   logic       is_common;
   logic       is_rt;
   logic [1:0] data_len;

   midi_byte_class u_class (
      .data           (data),
      .is_data        (is_data),
      .is_chan_status (is_chan_status),
      .is_common      (is_common),
      .is_rt          (is_rt),
      .data_len       (data_len)
   );

   state_e           state_q, state_d;
   logic [7:0]       run_status_q, run_status_d;
   logic [1:0]       run_len_q, run_len_d;
   logic             run_ok_q, run_ok_d;
   logic [6:0]       d1_q, d1_d;
   logic             ev_valid_q, ev_valid_d;
   logic [2:0]       ev_type_q, ev_type_d;
   logic [3:0]       ev_channel_q, ev_channel_d;
   logic [6:0]       ev_data1_q, ev_data1_d;
   logic [6:0]       ev_data2_q, ev_data2_d;
   logic [13:0]      ev_bend_q, ev_bend_d;
   logic             rt_valid_q, rt_valid_d;
   logic [2:0]       rt_code_q, rt_code_d;
   logic             rst_cmd_q, rst_cmd_d;
   logic [CNT_W-1:0] drop_cnt_q, drop_cnt_d;

   logic             take_d1;
   logic             done;
   logic             as_idle;
   logic [1:0]       inc;
   logic [6:0]       cd1;
   logic [6:0]       cd2;
   logic [2:0]       mtype;
   logic [CNT_W:0]   sum;

   always_comb begin
      state_d      = state_q;
      run_status_d = run_status_q;
      run_len_d    = run_len_q;
      run_ok_d     = run_ok_q;
      d1_d         = d1_q;
      ev_valid_d   = 1'b0;
      ev_type_d    = ev_type_q;
      ev_channel_d = ev_channel_q;
      ev_data1_d   = ev_data1_q;
      ev_data2_d   = ev_data2_q;
      ev_bend_d    = ev_bend_q;
      rt_valid_d   = 1'b0;
      rt_code_d    = rt_code_q;
      rst_cmd_d    = 1'b0;
      take_d1      = 1'b0;
      done         = 1'b0;
      as_idle      = 1'b0;
      inc          = 2'd0;
      cd1          = d1_q;
      cd2          = 7'd0;
      mtype        = run_status_q[6:4];
      sum          = '0;

      if (valid_byte) begin
         if (is_rt) begin
            if (data == RT_RESET) begin
               rst_cmd_d = 1'b1;
            end else begin
               rt_valid_d = 1'b1;
               rt_code_d  = data[2:0];
            end
         end else if (is_data) begin
            unique case (state_q)
               ST_IDLE: begin
                  if (run_ok_q && RUNNING_STATUS)
                     take_d1 = 1'b1;
                  else
                     inc = inc + 2'd1;
               end
               ST_WAIT_D1: take_d1 = 1'b1;
               ST_WAIT_D2: begin
                  done = 1'b1;
                  cd2  = data[6:0];
               end
               default: ;
            endcase
         end else begin
            as_idle = 1'b1;
            // a status byte mid-message abandons the partial message
            if (state_q == ST_WAIT_D1 || state_q == ST_WAIT_D2)
               inc = inc + 2'd1;
            if (state_q == ST_SYSEX && data == SYSEX_END) begin
               state_d = ST_IDLE;
               as_idle = 1'b0;
            end
            if (as_idle) begin
               if (is_chan_status) begin
                  run_status_d = data;
                  run_len_d    = data_len;
                  run_ok_d     = 1'b1;
                  state_d      = ST_WAIT_D1;
               end else if (is_common && data == SYSEX_START) begin
                  run_ok_d = 1'b0;
                  state_d  = ST_SYSEX;
               end else begin
                  run_ok_d = 1'b0;
                  state_d  = ST_IDLE;
                  inc      = inc + 2'd1;
               end
            end
         end
      end

      if (take_d1) begin
         if (run_len_q == 2'd1) begin
            done = 1'b1;
            cd1  = data[6:0];
         end else begin
            d1_d    = data[6:0];
            state_d = ST_WAIT_D2;
         end
      end

      if (done) begin
         state_d = ST_IDLE;
         if (CHAN_MASK[run_status_q[3:0]]) begin
            ev_valid_d   = 1'b1;
            ev_channel_d = run_status_q[3:0];
            ev_data1_d   = cd1;
            ev_data2_d   = cd2;
            if (VEL0_OFF && mtype == MSG_ON && cd2 == 7'd0)
               ev_type_d = MSG_OFF;
            else
               ev_type_d = mtype;
            if (mtype == MSG_BEND)
               ev_bend_d = {cd2, cd1};
         end else begin
            inc = inc + 2'd1;
         end
      end

      sum        = {1'b0, drop_cnt_q} + (CNT_W+1)'(inc);
      drop_cnt_d = sum[CNT_W] ? '1 : sum[CNT_W-1:0];
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q      <= ST_IDLE;
         run_status_q <= 8'd0;
         run_len_q    <= 2'd2;
         run_ok_q     <= 1'b0;
         d1_q         <= 7'd0;
         ev_valid_q   <= 1'b0;
         ev_type_q    <= 3'd0;
         ev_channel_q <= 4'd0;
         ev_data1_q   <= 7'd0;
         ev_data2_q   <= 7'd0;
         ev_bend_q    <= 14'd0;
         rt_valid_q   <= 1'b0;
         rt_code_q    <= 3'd0;
         rst_cmd_q    <= 1'b0;
         drop_cnt_q   <= '0;
      end else begin
         state_q      <= state_d;
         run_status_q <= run_status_d;
         run_len_q    <= run_len_d;
         run_ok_q     <= run_ok_d;
         d1_q         <= d1_d;
         ev_valid_q   <= ev_valid_d;
         ev_type_q    <= ev_type_d;
         ev_channel_q <= ev_channel_d;
         ev_data1_q   <= ev_data1_d;
         ev_data2_q   <= ev_data2_d;
         ev_bend_q    <= ev_bend_d;
         rt_valid_q   <= rt_valid_d;
         rt_code_q    <= rt_code_d;
         rst_cmd_q    <= rst_cmd_d;
         drop_cnt_q   <= drop_cnt_d;
      end
   end

   assign ev_valid   = ev_valid_q;
   assign ev_type    = ev_type_q;
   assign ev_channel = ev_channel_q;
   assign ev_data1   = ev_data1_q;
   assign ev_data2   = ev_data2_q;
   assign ev_bend    = ev_bend_q;
   assign rt_valid   = rt_valid_q;
   assign rt_code    = rt_code_q;
   assign rst_cmd    = rst_cmd_q;
   assign drop_cnt   = drop_cnt_q;

endmodule
